shiftleft_pipe: RTL and testbench

//  Pipelined 64-bit logical shift-left unit for the GPU ALU; complement of the combinational LSR.
//  Six log-stages (1,2,4,8,16,32), split into 3 registered pipe stages of 2 log-stages each.

---
 rtl/gpu_alu_pkg.sv | 12 +
 rtl/shl_pair_stage.sv | 22 ++
 rtl/shiftleft_pipe.sv | 78 +++++++
 tb/tb_shiftleft_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gpu_alu_pkg.sv
// gpu_alu_pkg: shared ALU widths and the shift-left pipe stage record
package gpu_alu_pkg;
   localparam int DATA_W  = 64;
   localparam int SHAMT_W = 6;
   localparam int TAG_W   = 5;
   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [SHAMT_W-1:0] shamt;
      logic [TAG_W-1:0]   tag;
      logic               ovf;
   } shl_stage_t;
endpackage

// File: rtl/shl_pair_stage.sv
// shl_pair_stage: combinational two-log-step left shift (by BASE, then by 2*BASE) with discarded-ones flag
// ports: d operand, amt[0] enables the BASE step, amt[1] the 2*BASE step,
//        q shifted result, lost set when any '1' bit is pushed past the MSB
module shl_pair_stage #(
   parameter int WIDTH = 64,
   parameter int BASE  = 1
) (
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       amt,
   output logic [WIDTH-1:0] q,
   output logic             lost
);
   logic [WIDTH-1:0] mid;
   logic             lost_lo, lost_hi;
   always_comb begin
      mid     = amt[0] ? d << BASE : d;
      lost_lo = amt[0] && |d[WIDTH-1 -: BASE];
      q       = amt[1] ? mid << (2 * BASE) : mid;
      lost_hi = amt[1] && |mid[WIDTH-1 -: 2 * BASE];
      lost    = lost_lo || lost_hi;
   end
endmodule

// File: rtl/shiftleft_pipe.sv
// shiftleft_pipe: 3-stage pipelined logical shift-left with valid/ready, tag sideband, zero and ovf flags
// ports: clk, rst (sync, active-high), flush clears every stage;
//        in_valid/in_ready/in_data/in_shamt/in_tag accept an op,
//        out_valid/out_ready/out_data/out_tag/out_zero/out_ovf return data<<shamt,
//        its tag, a zero flag and a flag for ones shifted past the MSB
module shiftleft_pipe #(
   parameter int WIDTH   = gpu_alu_pkg::DATA_W,
   parameter int SHAMT_W = gpu_alu_pkg::SHAMT_W,
   parameter int TAG_W   = gpu_alu_pkg::TAG_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_zero,
   output logic               out_ovf
);
   logic [2:0]       v;
   logic             adv0, adv1, adv2;
   logic [WIDTH-1:0] d0, d1, d2, q0, q1, q2;
   logic [TAG_W-1:0] t0, t1, t2;
   logic             o0, o1, o2, l0, l1, l2;
   logic [3:0]       r0;
   logic [1:0]       r1;
   // a stage moves on when empty or when its successor moves on
   assign adv2     = !v[2] || out_ready;
   assign adv1     = !v[1] || adv2;
   assign adv0     = !v[0] || adv1;
   assign in_ready = adv0;
   shl_pair_stage #(.WIDTH(WIDTH), .BASE(1))  u0 (.d(in_data), .amt(in_shamt[1:0]), .q(q0), .lost(l0));
   shl_pair_stage #(.WIDTH(WIDTH), .BASE(4))  u1 (.d(d0),      .amt(r0[1:0]),       .q(q1), .lost(l1));
   shl_pair_stage #(.WIDTH(WIDTH), .BASE(16)) u2 (.d(d1),      .amt(r1),            .q(q2), .lost(l2));
   always_ff @(posedge clk) begin
      if (rst) begin
         v  <= '0;
         d2 <= '0;
         t2 <= '0;
         o2 <= 1'b0;
      end else begin
         v[0] <= !flush && (adv0 ? in_valid : v[0]);
         v[1] <= !flush && (adv1 ? v[0] : v[1]);
         v[2] <= !flush && (adv2 ? v[1] : v[2]);
         if (adv2) begin
            d2 <= q2;
            t2 <= t1;
            o2 <= o1 || l2;
         end
      end
   end
   // inner stages carry only the shift bits not yet consumed
   always_ff @(posedge clk) begin
      if (adv0) begin
         d0 <= q0;
         r0 <= in_shamt[5:2];
         t0 <= in_tag;
         o0 <= l0;
      end
      if (adv1) begin
         d1 <= q1;
         r1 <= r0[3:2];
         t1 <= t0;
         o1 <= o0 || l1;
      end
   end
   assign out_valid = v[2];
   assign out_data  = d2;
   assign out_tag   = t2;
   assign out_ovf   = o2;
   assign out_zero  = v[2] && d2 == '0;
endmodule

// File: tb/tb_shiftleft_pipe.sv
// tb_shiftleft_pipe: scoreboard bench for shiftleft_pipe
module tb_shiftleft_pipe;
   import gpu_alu_pkg::*;
   typedef struct {
      shl_stage_t s;
      logic       zero;
      logic       lat;
      int         t;
   } exp_t;
   logic               clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
   logic               in_ready, out_valid, out_zero, out_ovf;
   logic [DATA_W-1:0]  in_data = '0, out_data;
   logic [SHAMT_W-1:0] in_shamt = '0;
   logic [TAG_W-1:0]   in_tag = '0, out_tag;
   int                 checks = 0, errors = 0, cyc = 0;
   exp_t               q[$];
   shl_stage_t         exp_nx;
   logic               lat_mode = 0, held = 0, done = 0;
   logic [DATA_W-1:0]  h_data;
   logic [TAG_W-1:0]   h_tag;
   logic               h_ovf;

   always #5 clk = ~clk;

   shiftleft_pipe dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .out_zero(out_zero), .out_ovf(out_ovf)
   );

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endfunction

   function automatic shl_stage_t ref_shl(logic [63:0] d, int s, logic [4:0] t);
      shl_stage_t r;
      r.data  = d << s;
      r.shamt = 6'(s);
      r.tag   = t;
      r.ovf   = (s == 0) ? 1'b0 : |(d >> (64 - s));
      return r;
   endfunction

   // monitor: samples 1 time unit before each rising edge
   always begin
      exp_t e;
      @(negedge clk);
      #4;
      cyc++;
      if (rst) begin
         q.delete();
         held = 0;
      end else begin
         if (held) begin
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_data", out_data, h_data);
            chk("stall_tag", 64'(out_tag), 64'(h_tag));
            chk("stall_ovf", 64'(out_ovf), 64'(h_ovf));
         end
         chk("in_ready", 64'(in_ready), 64'(!(q.size() == 3 && !out_ready)));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got tag %0d expected no output", out_tag);
            end else begin
               e = q.pop_front();
               chk("out_data", out_data, e.s.data);
               chk("out_tag", 64'(out_tag), 64'(e.s.tag));
               chk("out_ovf", 64'(out_ovf), 64'(e.s.ovf));
               chk("out_zero", 64'(out_zero), 64'(e.zero));
               if (e.lat) chk("latency", 64'(cyc - e.t), 64'(3));
            end
         end
         if (flush) q.delete();
         else if (in_valid && in_ready)
            q.push_back('{s: exp_nx, zero: exp_nx.data == '0, lat: lat_mode, t: cyc});
         held   = out_valid && !out_ready && !flush;
         h_data = out_data;
         h_tag  = out_tag;
         h_ovf  = out_ovf;
      end
   end

   // called at a falling edge; returns at the falling edge after acceptance
   task automatic op(input logic [63:0] d, input int s, input logic [4:0] t, input logic [63:0] ed, input logic eo);
      logic acc = 0;
      int   n = 0;
      in_valid = 1;
      in_data  = d;
      in_shamt = 6'(s);
      in_tag   = t;
      exp_nx   = '{data: ed, shamt: 6'(s), tag: t, ovf: eo};
      while (!acc && n < 100) begin
         #4;
         acc = in_ready;
         @(negedge clk);
         n++;
      end
      in_valid = 0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: tag %0d got not-accepted expected accepted", t);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(q.size()), 64'(0));
   endtask

   initial begin
      shl_stage_t r;
      repeat (2) @(negedge clk);
      rst = 0;
      #4;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", out_data, 64'(0));
      chk("rst_out_tag", 64'(out_tag), 64'(0));
      chk("rst_out_zero", 64'(out_zero), 64'(0));
      chk("rst_out_ovf", 64'(out_ovf), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      // single set bit walked through every shift amount
      lat_mode = 1;
      for (int s = 0; s < 64; s++) op(64'h1, s, 5'(s), 64'h1 << s, 1'b0);
      // directed boundary vectors
      op(64'h8000_0000_0000_0001, 1, 5'd1, 64'h2, 1'b1);
      op(64'h8000_0000_0000_0001, 63, 5'd2, 64'h8000_0000_0000_0000, 1'b1);
      op(64'hFFFF_FFFF_FFFF_FFFF, 63, 5'd3, 64'h8000_0000_0000_0000, 1'b1);
      op(64'h0, 17, 5'd4, 64'h0, 1'b0);
      op(64'h0123_4567_89AB_CDEF, 0, 5'd5, 64'h0123_4567_89AB_CDEF, 1'b0);
      drain();
      // stream with random backpressure
      lat_mode = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               r = ref_shl(64'hA5A5_0000_FFFF_1234 ^ {8{8'(i)}}, i * 7, 5'(i));
               op(64'hA5A5_0000_FFFF_1234 ^ {8{8'(i)}}, i * 7, 5'(i), r.data, r.ovf);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1;
      drain();
      // fill, stall, flush
      out_ready = 0;
      for (int i = 20; i < 23; i++) begin
         r = ref_shl(64'hF0F0, i, 5'(i));
         op(64'hF0F0, i, 5'(i), r.data, r.ovf);
      end
      flush = 1;
      @(negedge clk);
      flush = 0;
      #4;
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      out_ready = 1;
      lat_mode  = 1;
      op(64'h3, 62, 5'd23, 64'hC000_0000_0000_0000, 1'b0);
      drain();
      // reset mid-stream with an op offered
      op(64'h5, 1, 5'd24, 64'hA, 1'b0);
      op(64'h5, 2, 5'd25, 64'h14, 1'b0);
      rst      = 1;
      in_valid = 1;
      in_data  = 64'h7;
      in_shamt = 6'd3;
      in_tag   = 5'd27;
      @(negedge clk);
      rst      = 0;
      in_valid = 0;
      #4;
      chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_out_data", out_data, 64'(0));
      chk("mid_rst_out_tag", 64'(out_tag), 64'(0));
      chk("mid_rst_out_zero", 64'(out_zero), 64'(0));
      chk("mid_rst_out_ovf", 64'(out_ovf), 64'(0));
      chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
      repeat (8) @(negedge clk);
      chk("final_empty", 64'(q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
